// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: opcodes, writeback select,
// FSM states and the bundles carried through the MEM/WB register.
package mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [1:0] DTR_ALU = 2'b00;
  localparam logic [1:0] DTR_MEM = 2'b01;
  localparam logic [1:0] DTR_PC4 = 2'b10;
  localparam logic [1:0] DTR_RSV = 2'b11;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdatab;
    logic [31:0] inst;
    logic [4:0]  waddr;
    logic        regwrite;
    logic [1:0]  dtr;
    logic        memwrite;
  } mem_op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] memdata;
    logic [31:0] inst;
    logic [4:0]  waddr;
    logic        regwrite;
    logic [1:0]  dtr;
  } wb_t;

  // Unlisted opcodes fall back to a word access.
  function automatic size_e op_size(input logic [5:0] op);
    size_e sz;
    unique case (1'b1)
      (op == OP_LB) || (op == OP_LBU) || (op == OP_SB): sz = SZ_BYTE;
      (op == OP_LH) || (op == OP_LHU) || (op == OP_SH): sz = SZ_HALF;
      default:                                          sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic op_signed(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication and
// load lane extract with sign or zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  size_e       sz;
  logic        sgn;
  logic [31:0] shifted;
  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  // Size decode, lane pick and extension per access width.
  always_comb begin
    sz         = op_size(opcode);
    sgn        = op_signed(opcode);
    shifted    = ld_raw >> {addr_lo, 3'b000};
    b_sel      = shifted[7:0];
    h_sel      = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
    be         = 4'b1111;
    wdata      = st_data;
    ld_data    = ld_raw;
    misaligned = 1'b0;
    case (sz)
      SZ_BYTE: begin
        be      = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{sgn & b_sel[7]}}, b_sel};
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{st_data[15:0]}};
        ld_data    = {{16{sgn & h_sel[15]}}, h_sel};
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory req/ack sequencing with timeout,
// misalignment fault, and the MEM/WB pipeline register.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_PC,
  input  logic [31:0] MEM_ALUout,
  input  logic [31:0] MEM_rdataB,
  input  logic [31:0] MEM_inst,
  input  logic [4:0]  MEM_WriteAddr,
  input  logic        MEM_RegWrite,
  input  logic [1:0]  MEM_DataToReg,
  input  logic        MEM_MemWrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_busy,
  output logic        mem_fault,
  output logic [31:0] WB_PC,
  output logic [31:0] WB_ALUout,
  output logic [31:0] WB_MemData,
  output logic [31:0] WB_inst,
  output logic [4:0]  WB_WriteAddr,
  output logic        WB_RegWrite,
  output logic [1:0]  WB_DataToReg
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;
  mem_op_t       op_q, op_d;
  wb_t           wb_q, wb_d;

  mem_op_t     cur_op;
  mem_op_t     sel_op;
  logic        is_mem;
  logic        misaligned;
  logic        issue;
  logic [31:0] ld_data;

  function automatic wb_t mk_wb(input mem_op_t op,
                                input logic [31:0] ld);
    wb_t w;
    w.pc       = op.pc;
    w.alu      = op.alu;
    w.inst     = op.inst;
    w.waddr    = op.waddr;
    w.dtr      = op.dtr;
    w.regwrite = op.regwrite & ~op.memwrite;
    w.memdata  = (~op.memwrite && op.dtr == DTR_MEM) ? ld : 32'h0;
    return w;
  endfunction

  // Live bundle in IDLE, latched bundle while waiting on the bus.
  always_comb begin
    cur_op.pc       = MEM_PC;
    cur_op.alu      = MEM_ALUout;
    cur_op.rdatab   = MEM_rdataB;
    cur_op.inst     = MEM_inst;
    cur_op.waddr    = MEM_WriteAddr;
    cur_op.regwrite = MEM_RegWrite;
    cur_op.dtr      = MEM_DataToReg;
    cur_op.memwrite = MEM_MemWrite;
    sel_op = (state_q == WAIT) ? op_q : cur_op;
    is_mem = sel_op.memwrite | (sel_op.dtr == DTR_MEM);
  end

  mem_lane_align u_align (
    .opcode     (sel_op.inst[31:26]),
    .addr_lo    (sel_op.alu[1:0]),
    .st_data    (sel_op.rdatab),
    .ld_raw     (dmem_rdata),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .ld_data    (ld_data),
    .misaligned (misaligned)
  );

  // Bus drive; reset gates req so an abandoned access drops at once.
  always_comb begin
    issue     = is_mem & ~misaligned;
    dmem_req  = rst & issue;
    dmem_we   = sel_op.memwrite;
    dmem_addr = {sel_op.alu[31:2], 2'b00};
    mem_busy  = dmem_req & ~dmem_ack;
  end

  // Next-state, timeout counter, fault and writeback selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fault_d     = fault_q;
    op_d        = op_q;
    wb_d        = wb_q;
    wb_d.regwrite = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!is_mem) begin
          wb_d = mk_wb(cur_op, 32'h0);
        end else if (misaligned) begin
          fault_d = 1'b1;
        end else if (dmem_ack) begin
          wb_d = mk_wb(cur_op, ld_data);
        end else begin
          op_d    = cur_op;
          state_d = WAIT;
          cnt_d   = CW'(1);
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          wb_d    = mk_wb(op_q, ld_data);
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // State, latched op, sticky fault and MEM/WB register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      op_q    <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      op_q    <= op_d;
      wb_q    <= wb_d;
    end
  end

  assign mem_fault    = fault_q;
  assign WB_PC        = wb_q.pc;
  assign WB_ALUout    = wb_q.alu;
  assign WB_MemData   = wb_q.memdata;
  assign WB_inst      = wb_q.inst;
  assign WB_WriteAddr = wb_q.waddr;
  assign WB_RegWrite  = wb_q.regwrite;
  assign WB_DataToReg = wb_q.dtr;

endmodule
